// File: rtl/mem_pkg.sv
// Shared definitions for the memory access unit: RV32I load/store size codes,
// FSM state encoding and the store lane helpers.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    LOAD_WAIT,
    RESP
  } state_t;

  // Byte enables for a store of the given size at the given byte offset.
  function automatic logic [3:0] storeMask(input logic [2:0] funct3, input logic [1:0] offset);
    case (funct3)
      F3_B:    return 4'b0001 << offset;
      F3_H:    return 4'b0011 << offset;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate narrow store data so every lane carries it; byte enables pick the lane.
  function automatic logic [31:0] storeData(input logic [2:0] funct3, input logic [31:0] wdata);
    case (funct3)
      F3_B:    return {4{wdata[7:0]}};
      F3_H:    return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/halfword of a BRAM word and sign- or zero-extends it.
module load_align
  import mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] word,
  output logic [31:0] result
);

  logic [31:0] shifted;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first; a path that skips an assignment infers a latch.
    result  = word;
    shifted = word >> {addr, 3'b000};
    case (funct3)
      F3_B:    result = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   result = {24'h0, shifted[7:0]};
      F3_H:    result = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   result = {16'h0, shifted[15:0]};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between a RV32I core and BRAM port B, with one memory-mapped
// output register shadowing stores to MMIO_ADDR.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int          ADDR_WIDTH = 13,
  parameter logic [31:0] MMIO_ADDR  = 32'h0000_0FFC
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_store,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic                  mem_en,
  output logic [3:0]            mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_din,
  input  logic [31:0]           mem_dout,
  output logic [31:0]           mmio_dout
);

  state_t      state;
  logic [2:0]  loadFunct3;
  logic [1:0]  loadOffset;
  logic [31:0] respData;
  logic        respErr;
  logic [31:0] mmioReg;
  logic [31:0] alignedData;

  logic accept, misaligned, outOfRange, illegal, reqErr, mmioHit;

  always_comb begin
    misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0])
              || ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00));
    outOfRange = (req_addr >> (ADDR_WIDTH + 2)) != 32'h0;
    illegal    = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111)
              || (req_store && req_funct3[2]);
    reqErr     = misaligned || outOfRange || illegal;
    mmioHit    = req_addr[ADDR_WIDTH+1:2] == MMIO_ADDR[ADDR_WIDTH+1:2];
  end

  // Reset gates the handshake outputs so nothing leaks out in the first reset cycle.
  assign req_ready  = (state == IDLE) && !reset;
  assign accept     = req_valid && req_ready;
  assign mem_en     = accept && !reqErr;
  assign mem_we     = (mem_en && req_store) ? storeMask(req_funct3, req_addr[1:0]) : 4'b0000;
  assign mem_addr   = req_addr[ADDR_WIDTH+1:2];
  assign mem_din    = storeData(req_funct3, req_wdata);

  assign resp_valid = (state == RESP) && !reset;
  assign resp_rdata = resp_valid ? respData : 32'h0;
  assign resp_err   = resp_valid && respErr;
  assign mmio_dout  = reset ? 32'h0 : mmioReg;

  load_align u_load_align (
    .funct3 (loadFunct3),
    .addr   (loadOffset),
    .word   (mem_dout),
    .result (alignedData)
  );

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state      <= IDLE;
      loadFunct3 <= F3_W;
      loadOffset <= 2'b00;
      respData   <= 32'h0;
      respErr    <= 1'b0;
      mmioReg    <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            loadFunct3 <= req_funct3;
            loadOffset <= req_addr[1:0];
            respData   <= 32'h0;
            respErr    <= reqErr;
            state      <= (req_store || reqErr) ? RESP : LOAD_WAIT;
            if (mem_en && req_store && mmioHit) begin
              for (int i = 0; i < 4; i++) begin
                if (mem_we[i]) mmioReg[8*i +: 8] <= mem_din[8*i +: 8];
              end
            end
          end
        end
        LOAD_WAIT: begin
          respData <= alignedData;
          state    <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural read-first BRAM model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [12:0] mem_addr;
  logic [31:0] mem_din, mem_dout, mmio_dout;

  int errors = 0;
  int checks = 0;

  logic [31:0] ram [0:8191];

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_WIDTH(13), .MMIO_ADDR(32'h0000_0FFC)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .mmio_dout(mmio_dout)
  );

  always @(posedge clk) begin
    if (mem_en) begin
      mem_dout <= ram[mem_addr];
      for (int i = 0; i < 4; i++)
        if (mem_we[i]) ram[mem_addr][8*i +: 8] <= mem_din[8*i +: 8];
    end
  end

  // Results of the most recent access
  logic        c0Ready, c0En, respErrSeen, strayEn, strayData;
  logic [3:0]  c0We;
  logic [12:0] c0Addr;
  logic [31:0] c0Din, respData;
  int          lat;
  time         c0Time;

  task automatic doAccess(input logic store, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata);
    @(negedge clk);
    req_valid = 1'b1; req_store = store; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    #1;
    c0Ready = req_ready; c0En = mem_en; c0We = mem_we; c0Addr = mem_addr; c0Din = mem_din;
    c0Time = $time;
    @(posedge clk);
    lat = 0; respData = 32'h0; respErrSeen = 1'b0; strayEn = 1'b0; strayData = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      if (mem_en) strayEn = 1'b1;
      if (resp_valid) begin
        lat = k; respData = resp_rdata; respErrSeen = resp_err;
        break;
      end else if (resp_rdata !== 32'h0 || resp_err !== 1'b0) strayData = 1'b1;
    end
    checks++;
    if (c0Ready !== 1'b1) begin errors++; $display("FAIL accept@%h: req_ready=%b want 1", addr, c0Ready); end
    checks++;
    if (strayEn || strayData) begin
      errors++; $display("FAIL idle_outputs@%h: stray mem_en=%b stray resp data=%b want 0", addr, strayEn, strayData);
    end
  endtask

  task automatic expectResp(input string name, input int wantLat, input logic [31:0] wantData,
                            input logic wantErr);
    checks++;
    if (lat !== wantLat || respData !== wantData || respErrSeen !== wantErr) begin
      errors++;
      $display("FAIL %s: lat=%0d data=%h err=%b want lat=%0d data=%h err=%b",
               name, lat, respData, respErrSeen, wantLat, wantData, wantErr);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h0000_0FFC; req_wdata = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({req_ready, resp_valid, resp_err, mem_en, mem_we} !== 8'h00 || resp_rdata !== 32'h0
        || mmio_dout !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b rv=%b err=%b en=%b we=%b rdata=%h mmio=%h want all 0",
               req_ready, resp_valid, resp_err, mem_en, mem_we, resp_rdata, mmio_dout);
    end
    @(negedge clk);
    req_valid = 1'b0; reset = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_release: req_ready=%b want 1", req_ready); end
  endtask

  task automatic test_word;
    doAccess(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);
    checks++;
    if (c0En !== 1'b1 || c0We !== 4'b1111 || c0Addr !== 13'd4 || c0Din !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL sw_c0: en=%b we=%b addr=%0d din=%h want 1 1111 4 deadbeef", c0En, c0We, c0Addr, c0Din);
    end
    expectResp("sw_resp", 1, 32'h0, 1'b0);
    doAccess(1'b0, 3'b010, 32'h10, 32'h0);
    checks++;
    if (c0En !== 1'b1 || c0We !== 4'b0000 || c0Addr !== 13'd4) begin
      errors++; $display("FAIL lw_c0: en=%b we=%b addr=%0d want 1 0000 4", c0En, c0We, c0Addr);
    end
    expectResp("lw_resp", 2, 32'hDEAD_BEEF, 1'b0);
  endtask

  task automatic test_load_extend;
    doAccess(1'b1, 3'b010, 32'h20, 32'h80FF_7F01);
    expectResp("sw_0x20", 1, 32'h0, 1'b0);
    doAccess(1'b0, 3'b000, 32'h23, 32'h0); expectResp("lb_0x23",  2, 32'hFFFF_FF80, 1'b0);
    doAccess(1'b0, 3'b100, 32'h23, 32'h0); expectResp("lbu_0x23", 2, 32'h0000_0080, 1'b0);
    doAccess(1'b0, 3'b001, 32'h22, 32'h0); expectResp("lh_0x22",  2, 32'hFFFF_80FF, 1'b0);
    doAccess(1'b0, 3'b101, 32'h20, 32'h0); expectResp("lhu_0x20", 2, 32'h0000_7F01, 1'b0);
    doAccess(1'b0, 3'b000, 32'h21, 32'h0); expectResp("lb_0x21",  2, 32'h0000_007F, 1'b0);
  endtask

  task automatic test_store_lanes;
    doAccess(1'b1, 3'b000, 32'h31, 32'h0000_00AB);
    checks++;
    if (c0We !== 4'b0010 || c0Din !== 32'hABAB_ABAB) begin
      errors++; $display("FAIL sb_lanes: we=%b din=%h want 0010 abababab", c0We, c0Din);
    end
    doAccess(1'b1, 3'b001, 32'h32, 32'h0000_1234);
    checks++;
    if (c0We !== 4'b1100 || c0Din !== 32'h1234_1234) begin
      errors++; $display("FAIL sh_lanes: we=%b din=%h want 1100 12341234", c0We, c0Din);
    end
    doAccess(1'b0, 3'b010, 32'h30, 32'h0); expectResp("lw_merged", 2, 32'h1234_AB00, 1'b0);
  endtask

  task automatic test_errors;
    doAccess(1'b0, 3'b010, 32'h6, 32'h0);
    checks++;
    if (c0En !== 1'b0) begin errors++; $display("FAIL lw_mis_en: mem_en=%b want 0", c0En); end
    expectResp("lw_misaligned", 1, 32'h0, 1'b1);
    doAccess(1'b1, 3'b001, 32'h5, 32'h0000_5555);
    checks++;
    if (c0En !== 1'b0 || c0We !== 4'b0000) begin errors++; $display("FAIL sh_mis_en: en=%b we=%b want 0 0000", c0En, c0We); end
    expectResp("sh_misaligned", 1, 32'h0, 1'b1);
    doAccess(1'b0, 3'b010, 32'h8000, 32'h0); expectResp("lw_range", 1, 32'h0, 1'b1);
    doAccess(1'b0, 3'b011, 32'h10, 32'h0);   expectResp("ld_illegal", 1, 32'h0, 1'b1);
    doAccess(1'b1, 3'b100, 32'h10, 32'h0);   expectResp("sbu_illegal", 1, 32'h0, 1'b1);
    doAccess(1'b0, 3'b010, 32'h4, 32'h0);    expectResp("lw_untouched", 2, 32'h0, 1'b0);
  endtask

  task automatic test_mmio;
    doAccess(1'b1, 3'b010, 32'hFFC, 32'h1234_5678);
    checks++;
    if (mmio_dout !== 32'h1234_5678) begin errors++; $display("FAIL mmio_sw: mmio=%h want 12345678", mmio_dout); end
    doAccess(1'b1, 3'b000, 32'hFFC, 32'h0000_00AA);
    checks++;
    if (mmio_dout !== 32'h1234_56AA) begin errors++; $display("FAIL mmio_sb: mmio=%h want 123456aa", mmio_dout); end
    doAccess(1'b1, 3'b001, 32'hFFD, 32'h0000_FFFF);
    checks++;
    if (mmio_dout !== 32'h1234_56AA) begin errors++; $display("FAIL mmio_err_store: mmio=%h want 123456aa", mmio_dout); end
    doAccess(1'b0, 3'b010, 32'hFFC, 32'h0); expectResp("lw_mmio", 2, 32'h1234_56AA, 1'b0);
  endtask

  task automatic test_back_to_back;
    time t0;
    doAccess(1'b1, 3'b010, 32'h40, 32'h1111_1111); t0 = c0Time;
    doAccess(1'b1, 3'b010, 32'h44, 32'h2222_2222);
    checks++;
    if (c0Time - t0 !== 20) begin errors++; $display("FAIL store_rate: gap=%0t want 20", c0Time - t0); end
    t0 = c0Time;
    doAccess(1'b0, 3'b010, 32'h40, 32'h0);
    expectResp("b2b_lw0", 2, 32'h1111_1111, 1'b0);
    t0 = c0Time;
    doAccess(1'b0, 3'b010, 32'h44, 32'h0);
    expectResp("b2b_lw1", 2, 32'h2222_2222, 1'b0);
    checks++;
    if (c0Time - t0 !== 30) begin errors++; $display("FAIL load_rate: gap=%0t want 30", c0Time - t0); end
  endtask

  task automatic test_reset_mid_load;
    logic seen;
    seen = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'h0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; reset = 1'b1;
    #1;
    if (resp_valid) seen = 1'b1;
    repeat (2) begin
      @(negedge clk); #1;
      if (resp_valid) seen = 1'b1;
    end
    checks++;
    if (mmio_dout !== 32'h0) begin errors++; $display("FAIL reset_mmio: mmio=%h want 0", mmio_dout); end
    reset = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: req_ready=%b want 1", req_ready); end
    repeat (2) begin
      @(negedge clk); #1;
      if (resp_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL reset_discard: resp_valid seen=%b want 0", seen); end
    doAccess(1'b0, 3'b010, 32'h10, 32'h0);
    expectResp("lw_after_reset", 2, 32'hDEAD_BEEF, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) ram[i] = 32'h0;
    req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
    test_reset();
    test_word();
    test_load_extend();
    test_store_lanes();
    test_errors();
    test_mmio();
    test_back_to_back();
    test_reset_mid_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
